// File: rtl/stim_driver.sv
// Corner sweep then LFSR operand generator for the arithmetic test loop; operands appear on the edge that registers the state.
// Waits for i_mon_ready before driving; a drop of i_mon_ready while running aborts to IDLE; counts nonzero i_diff cycles.
module stim_driver #(
  parameter int          WIDTH     = 32,
  parameter int          NUM_VEC   = 1024,
  parameter int          DRAIN_CYC = 16,
  parameter logic [31:0] SEED      = 32'h0000_0001,
  parameter int          ERR_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_start,
  input  logic             i_mon_ready,
  input  logic [WIDTH-1:0] i_diff,
  output logic [WIDTH-1:0] o_dut_ia,
  output logic [WIDTH-1:0] o_dut_ib,
  output logic             o_valid,
  output logic             o_busy,
  output logic             o_done,
  output logic [ERR_W-1:0] o_err_cnt
);

  localparam int VW = $clog2(NUM_VEC) + 1;
  localparam int DW = $clog2(DRAIN_CYC + 1);

  localparam logic [31:0] SEED_A = (SEED == 32'h0) ? 32'h1 : SEED;
  localparam logic [31:0] SEED_B = (~SEED == 32'h0) ? 32'h1 : ~SEED;

  localparam logic [WIDTH-1:0] ALL1 = '1;
  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);
  localparam logic [WIDTH-1:0] MSB  = WIDTH'(1) << (WIDTH - 1);
  localparam logic [WIDTH-1:0] MAXP = ~MSB;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_WAIT   = 3'd1;
  localparam logic [2:0] S_CORNER = 3'd2;
  localparam logic [2:0] S_RANDOM = 3'd3;
  localparam logic [2:0] S_DRAIN  = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;

  logic [2:0]       state_q, state_d;
  logic [VW-1:0]    vec_cnt_q, vec_cnt_d;
  logic [DW-1:0]    drain_cnt_q, drain_cnt_d;
  logic [31:0]      lfsr_a_q, lfsr_a_d, lfsr_b_q, lfsr_b_d;
  logic [WIDTH-1:0] ia_q, ia_d, ib_q, ib_d;
  logic             valid_q, valid_d, busy_q, busy_d, done_q, done_d;
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
  logic             active, emit_corner, emit_rnd;
  logic [2:0]       corner_idx;

  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    return {s[30:0], s[31] ^ s[21] ^ s[1] ^ s[0]};
  endfunction

  function automatic logic [WIDTH-1:0] corner_a(input logic [2:0] idx);
    case (idx)
      3'd0, 3'd1: return '0;
      3'd4:       return ONE;
      3'd5:       return MSB;
      3'd6:       return MAXP;
      default:    return ALL1;
    endcase
  endfunction

  function automatic logic [WIDTH-1:0] corner_b(input logic [2:0] idx);
    case (idx)
      3'd0, 3'd2: return '0;
      3'd1, 3'd3: return ALL1;
      3'd5:       return MSB;
      default:    return ONE;
    endcase
  endfunction

  always_comb begin
    state_d     = state_q;
    vec_cnt_d   = vec_cnt_q;
    drain_cnt_d = drain_cnt_q;
    lfsr_a_d    = lfsr_a_q;
    lfsr_b_d    = lfsr_b_q;
    err_cnt_d   = err_cnt_q;
    ia_d        = '0;
    ib_d        = '0;
    valid_d     = 1'b0;
    emit_corner = 1'b0;
    emit_rnd    = 1'b0;
    corner_idx  = vec_cnt_q[2:0];
    active      = (state_q == S_CORNER) || (state_q == S_RANDOM) || (state_q == S_DRAIN);

    if (active && (|i_diff) && (err_cnt_q != '1))
      err_cnt_d = err_cnt_q + ERR_W'(1);

    case (state_q)
      S_IDLE, S_DONE: begin
        // Every run restarts from the seeds so sequences repeat exactly.
        if (i_start) begin
          state_d   = S_WAIT;
          err_cnt_d = '0;
          vec_cnt_d = '0;
          lfsr_a_d  = SEED_A;
          lfsr_b_d  = SEED_B;
        end
      end
      S_WAIT: begin
        if (i_mon_ready) begin
          state_d     = S_CORNER;
          corner_idx  = 3'd0;
          emit_corner = 1'b1;
        end
      end
      S_CORNER: begin
        if (vec_cnt_q == VW'(8)) begin
          state_d  = S_RANDOM;
          emit_rnd = 1'b1;
        end else begin
          emit_corner = 1'b1;
        end
      end
      S_RANDOM: begin
        if (vec_cnt_q == VW'(NUM_VEC)) begin
          state_d     = S_DRAIN;
          drain_cnt_d = DW'(1);
        end else begin
          emit_rnd = 1'b1;
        end
      end
      S_DRAIN: begin
        if (drain_cnt_q == DW'(DRAIN_CYC)) state_d = S_DONE;
        else                               drain_cnt_d = drain_cnt_q + DW'(1);
      end
      default: state_d = S_IDLE;
    endcase

    if (emit_corner) begin
      ia_d      = corner_a(corner_idx);
      ib_d      = corner_b(corner_idx);
      valid_d   = 1'b1;
      vec_cnt_d = vec_cnt_q + VW'(1);
    end
    if (emit_rnd) begin
      ia_d      = lfsr_a_q[WIDTH-1:0];
      ib_d      = lfsr_b_q[WIDTH-1:0];
      valid_d   = 1'b1;
      vec_cnt_d = vec_cnt_q + VW'(1);
      lfsr_a_d  = lfsr_next(lfsr_a_q);
      lfsr_b_d  = lfsr_next(lfsr_b_q);
    end

    // Monitor dropping out overrides everything except the error tally.
    if (active && !i_mon_ready) begin
      state_d     = S_IDLE;
      ia_d        = '0;
      ib_d        = '0;
      valid_d     = 1'b0;
      vec_cnt_d   = vec_cnt_q;
      drain_cnt_d = drain_cnt_q;
      lfsr_a_d    = lfsr_a_q;
      lfsr_b_d    = lfsr_b_q;
    end

    busy_d = (state_d != S_IDLE) && (state_d != S_DONE);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      vec_cnt_q   <= '0;
      drain_cnt_q <= '0;
      lfsr_a_q    <= SEED_A;
      lfsr_b_q    <= SEED_B;
      ia_q        <= '0;
      ib_q        <= '0;
      valid_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      vec_cnt_q   <= vec_cnt_d;
      drain_cnt_q <= drain_cnt_d;
      lfsr_a_q    <= lfsr_a_d;
      lfsr_b_q    <= lfsr_b_d;
      ia_q        <= ia_d;
      ib_q        <= ib_d;
      valid_q     <= valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign o_dut_ia  = ia_q;
  assign o_dut_ib  = ib_q;
  assign o_valid   = valid_q;
  assign o_busy    = busy_q;
  assign o_done    = done_q;
  assign o_err_cnt = err_cnt_q;

endmodule

// File: tb/tb_stim_driver.sv
// Bench for stim_driver: WIDTH=8, NUM_VEC=20, DRAIN_CYC=4; a second instance with ERR_W=2 shares all inputs.
module tb_stim_driver;

  localparam int W   = 8;
  localparam int NV  = 20;
  localparam int DC  = 4;
  localparam int RUN = NV + DC;

  logic         clk, reset, i_start, i_mon_ready;
  logic [W-1:0] i_diff;
  logic [W-1:0] ia, ib, s_ia, s_ib;
  logic         valid, busy, done, s_valid, s_busy, s_done;
  logic [15:0]  err;
  logic [1:0]   s_err;

  stim_driver #(.WIDTH(W), .NUM_VEC(NV), .DRAIN_CYC(DC), .SEED(32'h1), .ERR_W(16)) dut (
    .clk(clk), .reset(reset), .i_start(i_start), .i_mon_ready(i_mon_ready), .i_diff(i_diff),
    .o_dut_ia(ia), .o_dut_ib(ib), .o_valid(valid), .o_busy(busy), .o_done(done), .o_err_cnt(err));

  stim_driver #(.WIDTH(W), .NUM_VEC(NV), .DRAIN_CYC(DC), .SEED(32'h1), .ERR_W(2)) dut_sat (
    .clk(clk), .reset(reset), .i_start(i_start), .i_mon_ready(i_mon_ready), .i_diff(i_diff),
    .o_dut_ia(s_ia), .o_dut_ib(s_ib), .o_valid(s_valid), .o_busy(s_busy), .o_done(s_done), .o_err_cnt(s_err));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] diff;
    logic       vld;
    logic [7:0] a;
    logic [7:0] b;
  } vec_t;

  vec_t       tbl [RUN];
  logic [7:0] m_a [NV];
  logic [7:0] m_b [NV];
  int n_chk  = 0;
  int n_pass = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
  endtask

  // Reference sequence from the plain rules: corner list, then both generators stepped per vector.
  task automatic build_model();
    logic [31:0] sa, sb;
    logic [7:0]  mm, hh, pp;
    mm = 8'((1 << W) - 1);
    hh = 8'(1 << (W - 1));
    pp = hh - 8'd1;
    m_a[0] = 0;  m_b[0] = 0;
    m_a[1] = 0;  m_b[1] = mm;
    m_a[2] = mm; m_b[2] = 0;
    m_a[3] = mm; m_b[3] = mm;
    m_a[4] = 1;  m_b[4] = 1;
    m_a[5] = hh; m_b[5] = hh;
    m_a[6] = pp; m_b[6] = 1;
    m_a[7] = mm; m_b[7] = 1;
    sa = 32'h1;
    sb = ~32'h1;
    for (int k = 8; k < NV; k++) begin
      m_a[k] = sa[7:0];
      m_b[k] = sb[7:0];
      sa = {sa[30:0], sa[31] ^ sa[21] ^ sa[1] ^ sa[0]};
      sb = {sb[30:0], sb[31] ^ sb[21] ^ sb[1] ^ sb[0]};
    end
  endtask

  task automatic check_vec(input string nm, input int k);
    chk({nm, "_valid"}, 32'(valid), 32'(k < NV));
    chk({nm, "_a"}, 32'(ia), (k < NV) ? 32'(m_a[k]) : 32'h0);
    chk({nm, "_b"}, 32'(ib), (k < NV) ? 32'(m_b[k]) : 32'h0);
  endtask

  initial begin
    logic [7:0] c_a [8];
    logic [7:0] c_b [8];
    logic [7:0] d;
    int vcnt, ecnt;

    reset = 1'b1; i_start = 1'b0; i_mon_ready = 1'b1; i_diff = '0;
    build_model();

    c_a = '{8'h00, 8'h00, 8'hFF, 8'hFF, 8'h01, 8'h80, 8'h7F, 8'hFF};
    c_b = '{8'h00, 8'hFF, 8'h00, 8'hFF, 8'h01, 8'h80, 8'h01, 8'h01};
    for (int k = 0; k < RUN; k++) begin
      tbl[k].diff = 8'h00;
      tbl[k].vld  = (k < NV);
      tbl[k].a    = (k < 8) ? c_a[k] : (k < NV) ? m_a[k] : 8'h00;
      tbl[k].b    = (k < 8) ? c_b[k] : (k < NV) ? m_b[k] : 8'h00;
    end
    tbl[8].a = 8'h01;  tbl[8].b = 8'hFE;
    tbl[9].a = 8'h03;  tbl[9].b = 8'hFD;
    tbl[10].a = 8'h06; tbl[10].b = 8'hFB;
    tbl[10].diff = 8'h01; tbl[13].diff = 8'h80; tbl[17].diff = 8'h10; tbl[21].diff = 8'h04;

    tick(); tick();
    chk("rst_valid", 32'(valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_ops", {16'(ia), 16'(ib)}, 0);
    chk("rst_err", 32'(err), 0);
    reset = 1'b0;
    tick();
    chk("idle_busy", 32'(busy), 0);

    // Run 1: table-driven corner sweep, first random vectors, run length, error count.
    i_start = 1'b1; tick(); i_start = 1'b0;
    chk("wait_busy", 32'(busy), 1);
    chk("wait_valid", 32'(valid), 0);
    tick();
    vcnt = 0;
    for (int k = 0; k < RUN; k++) begin
      chk($sformatf("t%0d_valid", k), 32'(valid), 32'(tbl[k].vld));
      chk($sformatf("t%0d_ops", k), {16'(ia), 16'(ib)}, {16'(tbl[k].a), 16'(tbl[k].b)});
      chk($sformatf("t%0d_done", k), 32'(done), 0);
      vcnt += int'(valid);
      i_diff = tbl[k].diff;
      tick();
      i_diff = '0;
    end
    chk("r1_done", 32'(done), 1);
    chk("r1_busy", 32'(busy), 0);
    chk("r1_vcnt", 32'(vcnt), NV);
    chk("r1_err", 32'(err), 4);
    chk("r1_err_sat", 32'(s_err), 3);
    i_diff = 8'h55;
    tick(); tick(); tick();
    i_diff = '0;
    chk("done_err_hold", 32'(err), 4);
    chk("done_still", 32'(done), 1);

    // Run 2: repeat run, ignored start mid-RANDOM, saturation over 10 error cycles.
    i_start = 1'b1; tick(); i_start = 1'b0;
    chk("r2_err_clr", 32'(err), 0);
    chk("r2_done_clr", 32'(done), 0);
    tick();
    for (int k = 0; k < RUN; k++) begin
      check_vec($sformatf("r2_%0d", k), k);
      if (k == 13) chk("r2_busy_after_start", 32'(busy), 1);
      i_diff  = (k >= 2 && k < 12) ? 8'h01 : 8'h00;
      i_start = (k == 12);
      tick();
      i_start = 1'b0;
    end
    i_diff = '0;
    chk("r2_done", 32'(done), 1);
    chk("r2_err", 32'(err), 10);
    chk("r2_err_sat", 32'(s_err), 3);
    tick(); tick();
    chk("r2_sat_hold", 32'(s_err), 3);

    // Run 3: ready gating, then abort with a simultaneous start.
    i_mon_ready = 1'b0;
    i_start = 1'b1; tick(); i_start = 1'b0;
    for (int c = 0; c < 5; c++) begin
      chk($sformatf("gate%0d_busy", c), 32'(busy), 1);
      chk($sformatf("gate%0d_valid", c), 32'(valid), 0);
      chk($sformatf("gate%0d_ops", c), {16'(ia), 16'(ib)}, 0);
      tick();
    end
    i_mon_ready = 1'b1;
    tick();
    for (int k = 0; k < 10; k++) begin
      check_vec($sformatf("r3_%0d", k), k);
      i_diff = (k == 9) ? 8'h01 : 8'h00;
      tick();
    end
    i_diff = '0;
    check_vec("r3_10", 10);
    i_mon_ready = 1'b0; i_start = 1'b1;
    tick();
    i_start = 1'b0; i_mon_ready = 1'b1;
    chk("abort_busy", 32'(busy), 0);
    chk("abort_valid", 32'(valid), 0);
    chk("abort_done", 32'(done), 0);
    chk("abort_ops", {16'(ia), 16'(ib)}, 0);
    chk("abort_err", 32'(err), 1);
    tick();
    chk("abort_idle_busy", 32'(busy), 0);
    chk("abort_idle_done", 32'(done), 0);

    // Run 4: reset asserted in DRAIN.
    i_start = 1'b1; tick(); i_start = 1'b0;
    tick();
    for (int k = 0; k < 21; k++) begin
      i_diff = (k == 0) ? 8'h01 : 8'h00;
      tick();
    end
    i_diff = '0;
    chk("drain_busy", 32'(busy), 1);
    chk("drain_valid", 32'(valid), 0);
    chk("drain_err", 32'(err), 1);
    reset = 1'b1; tick(); reset = 1'b0;
    chk("mrst_busy", 32'(busy), 0);
    chk("mrst_done", 32'(done), 0);
    chk("mrst_valid", 32'(valid), 0);
    chk("mrst_err", 32'(err), 0);
    tick();
    chk("mrst_idle", 32'(busy), 0);

    // Randomized runs against the sequence model and an error tally.
    for (int r = 0; r < 6; r++) begin
      int gap;
      gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) tick();
      i_start = 1'b1; tick(); i_start = 1'b0;
      chk($sformatf("rnd%0d_wait", r), 32'(busy), 1);
      tick();
      ecnt = 0;
      for (int k = 0; k < RUN; k++) begin
        check_vec($sformatf("rnd%0d_%0d", r, k), k);
        d = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
        if (d != 0) ecnt++;
        i_diff  = d;
        i_start = ($urandom_range(0, 7) == 0);
        tick();
        i_start = 1'b0;
      end
      i_diff = '0;
      chk($sformatf("rnd%0d_done", r), 32'(done), 1);
      chk($sformatf("rnd%0d_err", r), 32'(err), 32'(ecnt));
      chk($sformatf("rnd%0d_err_sat", r), 32'(s_err), (ecnt > 3) ? 3 : 32'(ecnt));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
